// File: rtl/pw_pkg.sv
// Shared types and widths for the sliding-window price buffer
// and the indicator blocks that consume its per-sample results.
package pw_pkg;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int PW_DEPTH = 14;
   localparam int PW_DW    = 16;
   localparam int PW_NCH   = 4;

   localparam int PW_CHW = clog2_min1(PW_NCH);
   localparam int PW_PW  = $clog2(PW_DEPTH);
   localparam int PW_CW  = $clog2(PW_DEPTH + 1);
   localparam int PW_SW  = PW_DW + $clog2(PW_DEPTH);

   typedef logic [PW_DW-1:0] price_t;

   typedef struct packed {
      logic [PW_CHW-1:0] ch;
      price_t            newest;
      price_t            oldest;
      logic              evict;
      logic [PW_SW-1:0]  sum;
      logic [PW_CW-1:0]  count;
      logic              full;
   } pw_result_t;

endpackage

// File: rtl/pw_channel_state.sv
// Per-channel write pointer, fill count and running sum, with
// next-state logic for write, flush and eviction.
module pw_channel_state
   import pw_pkg::*;
#(
   parameter int  DEPTH = PW_DEPTH,
   parameter int  DW    = PW_DW,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int SW    = DW + $clog2(DEPTH)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          i_wr,
   input  logic          i_flush,
   input  logic [DW-1:0] i_price,
   input  logic [DW-1:0] i_old,
   output logic [PW-1:0] o_rd_ptr,
   output logic [PW-1:0] o_wr_addr,
   output logic          o_evict,
   output logic [SW-1:0] o_next_sum,
   output logic [CW-1:0] o_next_count
);

   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic [SW-1:0] r_sum;

   logic [PW-1:0] w_base_ptr;
   logic [PW-1:0] w_ptr_inc;
   logic [CW-1:0] w_base_count;
   logic [SW-1:0] w_base_sum;
   logic          w_full;

   // A same-cycle flush empties the channel before the sample lands.
   always_comb begin
      w_base_ptr   = i_flush ? '0 : r_wr_ptr;
      w_base_count = i_flush ? '0 : r_count;
      w_base_sum   = i_flush ? '0 : r_sum;
      w_full       = (w_base_count == CNT_FULL);
      w_ptr_inc    = (w_base_ptr == PTR_LAST) ? '0 : w_base_ptr + 1'b1;
      o_evict      = i_wr && w_full;
      o_next_count = w_full ? w_base_count : w_base_count + 1'b1;
      o_next_sum   = w_base_sum + SW'(i_price)
                   - (w_full ? SW'(i_old) : '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_sum    <= '0;
      end else if (i_wr) begin
         r_wr_ptr <= w_ptr_inc;
         r_count  <= o_next_count;
         r_sum    <= o_next_sum;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_sum    <= '0;
      end
   end

   assign o_rd_ptr  = r_wr_ptr;
   assign o_wr_addr = w_base_ptr;

endmodule

// File: rtl/price_window_buffer.sv
// Multi-channel sliding-window price store: per accepted sample it
// reports newest, evicted price, window sum and fill count.
module price_window_buffer
   import pw_pkg::*;
#(
   parameter int  DEPTH = PW_DEPTH,
   parameter int  DW    = PW_DW,
   parameter int  NCH   = PW_NCH,
   localparam int CHW   = clog2_min1(NCH),
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int SW    = DW + $clog2(DEPTH)
)(
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [CHW-1:0] in_ch,
   input  logic [DW-1:0]  in_price,
   input  logic           flush,
   input  logic [CHW-1:0] flush_ch,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [CHW-1:0] out_ch,
   output logic [DW-1:0]  out_newest,
   output logic [DW-1:0]  out_oldest,
   output logic           out_evict,
   output logic [SW-1:0]  out_sum,
   output logic [CW-1:0]  out_count,
   output logic           out_full
);

   logic [DW-1:0] r_mem [NCH][DEPTH];

   logic [PW-1:0]  w_rd_ptr  [NCH];
   logic [PW-1:0]  w_wr_addr [NCH];
   logic [SW-1:0]  w_sum_n   [NCH];
   logic [CW-1:0]  w_cnt_n   [NCH];
   logic [NCH-1:0] w_evict;
   logic           w_accept;
   logic [DW-1:0]  w_old;

   logic           r_out_valid;
   logic [CHW-1:0] r_out_ch;
   logic [DW-1:0]  r_out_newest;
   logic [DW-1:0]  r_out_oldest;
   logic           r_out_evict;
   logic [SW-1:0]  r_out_sum;
   logic [CW-1:0]  r_out_count;
   logic           r_out_full;

   assign in_ready = !r_out_valid || out_ready;
   assign w_accept = in_valid && in_ready;

   // Once full, the write pointer addresses the oldest entry.
   assign w_old = r_mem[in_ch][w_rd_ptr[in_ch]];

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      pw_channel_state #(
         .DEPTH (DEPTH),
         .DW    (DW)
      ) u_state (
         .clk          (clk),
         .rst          (rst),
         .i_wr         (w_accept && (in_ch == CHW'(g))),
         .i_flush      (flush && (flush_ch == CHW'(g))),
         .i_price      (in_price),
         .i_old        (w_old),
         .o_rd_ptr     (w_rd_ptr[g]),
         .o_wr_addr    (w_wr_addr[g]),
         .o_evict      (w_evict[g]),
         .o_next_sum   (w_sum_n[g]),
         .o_next_count (w_cnt_n[g])
      );
   end

   always_ff @(posedge clk) begin
      if (w_accept)
         r_mem[in_ch][w_wr_addr[in_ch]] <= in_price;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_ch     <= '0;
         r_out_newest <= '0;
         r_out_oldest <= '0;
         r_out_evict  <= 1'b0;
         r_out_sum    <= '0;
         r_out_count  <= '0;
         r_out_full   <= 1'b0;
      end else if (w_accept) begin
         r_out_valid  <= 1'b1;
         r_out_ch     <= in_ch;
         r_out_newest <= in_price;
         r_out_oldest <= w_evict[in_ch] ? w_old : '0;
         r_out_evict  <= w_evict[in_ch];
         r_out_sum    <= w_sum_n[in_ch];
         r_out_count  <= w_cnt_n[in_ch];
         r_out_full   <= (w_cnt_n[in_ch] == CW'(DEPTH));
      end else if (out_ready) begin
         r_out_valid  <= 1'b0;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_ch     = r_out_ch;
   assign out_newest = r_out_newest;
   assign out_oldest = r_out_oldest;
   assign out_evict  = r_out_evict;
   assign out_sum    = r_out_sum;
   assign out_count  = r_out_count;
   assign out_full   = r_out_full;

endmodule

// File: tb/tb_price_window_buffer.sv
// Scoreboard bench for price_window_buffer: a window model predicts
// each result when a sample is accepted; results are popped on output.
`timescale 1ns/1ps
module tb_price_window_buffer;
   import pw_pkg::*;

   localparam int DEPTH = PW_DEPTH;
   localparam int DW    = PW_DW;
   localparam int NCH   = PW_NCH;
   localparam int CHW   = PW_CHW;
   localparam int CW    = PW_CW;
   localparam int SW    = PW_SW;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [CHW-1:0] in_ch;
   logic [DW-1:0]  in_price;
   logic           flush;
   logic [CHW-1:0] flush_ch;
   logic           out_valid;
   logic           out_ready;
   logic [CHW-1:0] out_ch;
   logic [DW-1:0]  out_newest;
   logic [DW-1:0]  out_oldest;
   logic           out_evict;
   logic [SW-1:0]  out_sum;
   logic [CW-1:0]  out_count;
   logic           out_full;

   always #5 clk = ~clk;

   price_window_buffer dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_ch      (in_ch),
      .in_price   (in_price),
      .flush      (flush),
      .flush_ch   (flush_ch),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_ch     (out_ch),
      .out_newest (out_newest),
      .out_oldest (out_oldest),
      .out_evict  (out_evict),
      .out_sum    (out_sum),
      .out_count  (out_count),
      .out_full   (out_full)
   );

   int n_cmp = 0;
   int n_err = 0;

   pw_result_t  sb [$];
   int unsigned win [NCH][DEPTH];
   int          cnt [NCH];

   function automatic pw_result_t observe();
      pw_result_t r;
      r.ch     = out_ch;
      r.newest = out_newest;
      r.oldest = out_oldest;
      r.evict  = out_evict;
      r.sum    = out_sum;
      r.count  = out_count;
      r.full   = out_full;
      return r;
   endfunction

   task automatic model_clear();
      for (int c = 0; c < NCH; c++) cnt[c] = 0;
      sb.delete();
   endtask

   task automatic model_accept(input int ch, input int unsigned p);
      pw_result_t  r;
      int unsigned s;
      r        = '0;
      r.ch     = CHW'(ch);
      r.newest = DW'(p);
      if (cnt[ch] == DEPTH) begin
         r.evict  = 1'b1;
         r.oldest = DW'(win[ch][0]);
         for (int i = 0; i < DEPTH - 1; i++) win[ch][i] = win[ch][i+1];
         win[ch][DEPTH-1] = p;
      end else begin
         win[ch][cnt[ch]] = p;
         cnt[ch]++;
      end
      s = 0;
      for (int i = 0; i < cnt[ch]; i++) s += win[ch][i];
      r.sum   = SW'(s);
      r.count = CW'(cnt[ch]);
      r.full  = (cnt[ch] == DEPTH);
      sb.push_back(r);
   endtask

   task automatic drive(input bit v, input int ch, input int unsigned p,
                        input bit ordy, input bit fl, input int fch,
                        output bit acc);
      in_valid  = v;
      in_ch     = CHW'(ch);
      in_price  = DW'(p);
      out_ready = ordy;
      flush     = fl;
      flush_ch  = CHW'(fch);
      #1;
      acc = v && in_ready;
      if (fl) cnt[fch] = 0;
      if (acc) model_accept(ch, p);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      in_valid  = 0; in_ch = '0; in_price = '0;
      flush     = 0; flush_ch = '0; out_ready = 1;
      rst       = 1;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_valid: got %b expected 0", out_valid);
      end
      n_cmp++;
      if (observe() !== pw_result_t'('0)) begin
         n_err++;
         $display("FAIL reset_outs: got %h expected 0", observe());
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready: got %b expected 1", in_ready);
      end
      rst = 0;
      tick();
   endtask

   task automatic test_fill();
      pw_result_t exp, obs, last;
      bit acc;
      last = '0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         drive(i < DEPTH, 0, 100 + i, 1, 0, 0, acc);
         if (out_valid && out_ready) begin
            n_cmp++;
            obs = observe();
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL fill: unexpected result %h", obs);
            end else begin
               exp = sb.pop_front();
               last = obs;
               if (obs !== exp) begin
                  n_err++;
                  $display("FAIL fill: got %h expected %h", obs, exp);
               end
            end
         end
         tick();
      end
      n_cmp++;
      if (last.sum !== SW'(1491) || last.count !== CW'(14)
          || last.full !== 1'b1) begin
         n_err++;
         $display("FAIL fill_final: got sum %0d cnt %0d full %b expected 1491 14 1",
                  last.sum, last.count, last.full);
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL fill_drain: got %0d pending expected 0", sb.size());
      end
   endtask

   task automatic test_wrap();
      pw_result_t exp, obs;
      pw_result_t res [2];
      int k = 0;
      bit acc;
      res[0] = '0; res[1] = '0;
      for (int i = 0; i < 3; i++) begin
         drive(i < 2, 0, 200 + i, 1, 0, 0, acc);
         if (out_valid && out_ready) begin
            n_cmp++;
            obs = observe();
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL wrap: unexpected result %h", obs);
            end else begin
               exp = sb.pop_front();
               if (k < 2) res[k] = obs;
               k++;
               if (obs !== exp) begin
                  n_err++;
                  $display("FAIL wrap: got %h expected %h", obs, exp);
               end
            end
         end
         tick();
      end
      n_cmp++;
      if (res[0].oldest !== DW'(100) || res[0].sum !== SW'(1591)
          || res[0].evict !== 1'b1 || res[0].count !== CW'(14)) begin
         n_err++;
         $display("FAIL wrap_first: got old %0d sum %0d expected 100 1591",
                  res[0].oldest, res[0].sum);
      end
      n_cmp++;
      if (res[1].oldest !== DW'(101) || res[1].sum !== SW'(1691)) begin
         n_err++;
         $display("FAIL wrap_second: got old %0d sum %0d expected 101 1691",
                  res[1].oldest, res[1].sum);
      end
   endtask

   task automatic test_interleave();
      pw_result_t exp, obs;
      pw_result_t last [2];
      bit acc;
      last[0] = '0; last[1] = '0;
      drive(0, 0, 0, 1, 1, 0, acc);
      tick();
      drive(0, 0, 0, 1, 1, 1, acc);
      tick();
      for (int i = 0; i < 7; i++) begin
         drive(i < 6, i % 2, (i % 2) ? 20 : 10, 1, 0, 0, acc);
         if (out_valid && out_ready) begin
            n_cmp++;
            obs = observe();
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL interleave: unexpected result %h", obs);
            end else begin
               exp = sb.pop_front();
               if (obs.ch < 2) last[obs.ch] = obs;
               if (obs !== exp) begin
                  n_err++;
                  $display("FAIL interleave: got %h expected %h", obs, exp);
               end
            end
         end
         tick();
      end
      n_cmp++;
      if (last[0].sum !== SW'(30) || last[0].count !== CW'(3)) begin
         n_err++;
         $display("FAIL interleave_ch0: got sum %0d cnt %0d expected 30 3",
                  last[0].sum, last[0].count);
      end
      n_cmp++;
      if (last[1].sum !== SW'(60) || last[1].count !== CW'(3)) begin
         n_err++;
         $display("FAIL interleave_ch1: got sum %0d cnt %0d expected 60 3",
                  last[1].sum, last[1].count);
      end
   endtask

   task automatic test_stall();
      pw_result_t exp, obs, snap;
      bit acc;
      int n_acc = 0;
      int p = 300;
      snap = '0;
      for (int i = 0; i < 5; i++) begin
         drive(1, 3, p, 0, 0, 0, acc);
         if (acc) begin n_acc++; p++; end
         if (i == 1) snap = observe();
         if (i >= 1) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin
               n_err++;
               $display("FAIL stall_ready: got %b expected 0", in_ready);
            end
         end
         if (i >= 2) begin
            n_cmp++;
            if (observe() !== snap) begin
               n_err++;
               $display("FAIL stall_hold: got %h expected %h", observe(), snap);
            end
         end
         tick();
      end
      n_cmp++;
      if (n_acc != 1) begin
         n_err++;
         $display("FAIL stall_accepts: got %0d expected 1", n_acc);
      end
      for (int i = 0; i < 6; i++) begin
         drive(p < 304, 3, p, 1, 0, 0, acc);
         if (acc) p++;
         if (out_valid && out_ready) begin
            n_cmp++;
            obs = observe();
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL stall_release: unexpected result %h", obs);
            end else begin
               exp = sb.pop_front();
               if (obs !== exp) begin
                  n_err++;
                  $display("FAIL stall_release: got %h expected %h", obs, exp);
               end
            end
         end
         tick();
      end
      n_cmp++;
      if (p != 304 || sb.size() != 0) begin
         n_err++;
         $display("FAIL stall_stream: got next %0d pending %0d expected 304 0",
                  p, sb.size());
      end
   endtask

   task automatic test_flush_same();
      int chs [10] = '{2, 2, 2, 2, 2, 2, 1, 3, 0, 0};
      int prs [10] = '{11, 12, 13, 14, 15, 50, 21, 31, 41, 0};
      bit fls [10] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
      int fcs [10] = '{0, 0, 0, 0, 0, 2, 0, 0, 0, 0};
      pw_result_t exp, obs;
      pw_result_t res [9];
      int k = 0;
      bit acc;
      for (int i = 0; i < 9; i++) res[i] = '0;
      for (int i = 0; i < 10; i++) begin
         drive(i < 9, chs[i], prs[i], 1, fls[i], fcs[i], acc);
         if (out_valid && out_ready) begin
            n_cmp++;
            obs = observe();
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL flush: unexpected result %h", obs);
            end else begin
               exp = sb.pop_front();
               if (k < 9) res[k] = obs;
               k++;
               if (obs !== exp) begin
                  n_err++;
                  $display("FAIL flush: got %h expected %h", obs, exp);
               end
            end
         end
         tick();
      end
      n_cmp++;
      if (res[5].count !== CW'(1) || res[5].sum !== SW'(50)
          || res[5].evict !== 1'b0) begin
         n_err++;
         $display("FAIL flush_same: got cnt %0d sum %0d ev %b expected 1 50 0",
                  res[5].count, res[5].sum, res[5].evict);
      end
      n_cmp++;
      if (res[6].count !== CW'(4) || res[6].sum !== SW'(81)) begin
         n_err++;
         $display("FAIL flush_other: got cnt %0d sum %0d expected 4 81",
                  res[6].count, res[6].sum);
      end
      n_cmp++;
      if (res[8].count !== CW'(1) || res[8].sum !== SW'(41)) begin
         n_err++;
         $display("FAIL flush_diff_ch: got cnt %0d sum %0d expected 1 41",
                  res[8].count, res[8].sum);
      end
   endtask

   task automatic test_async_reset();
      pw_result_t exp, obs;
      pw_result_t res [2];
      int k = 0;
      bit acc;
      res[0] = '0; res[1] = '0;
      drive(1, 0, 5, 0, 0, 0, acc);
      tick();
      drive(0, 0, 0, 0, 0, 0, acc);
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL areset_pre: got valid %b expected 1", out_valid);
      end
      #1 rst = 1;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || observe() !== pw_result_t'('0)) begin
         n_err++;
         $display("FAIL areset_drop: got valid %b outs %h expected 0 0",
                  out_valid, observe());
      end
      model_clear();
      #1 rst = 0;
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(i < 2, (i == 0) ? 1 : 0, (i == 0) ? 77 : 9, 1, 0, 0, acc);
         if (out_valid && out_ready) begin
            n_cmp++;
            obs = observe();
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL areset_after: unexpected result %h", obs);
            end else begin
               exp = sb.pop_front();
               if (k < 2) res[k] = obs;
               k++;
               if (obs !== exp) begin
                  n_err++;
                  $display("FAIL areset_after: got %h expected %h", obs, exp);
               end
            end
         end
         tick();
      end
      n_cmp++;
      if (res[0].count !== CW'(1) || res[0].sum !== SW'(77)
          || res[1].count !== CW'(1) || res[1].sum !== SW'(9)
          || res[1].evict !== 1'b0) begin
         n_err++;
         $display("FAIL areset_empty: got %0d/%0d %0d/%0d expected 1/77 1/9",
                  res[0].count, res[0].sum, res[1].count, res[1].sum);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_fill();
      test_wrap();
      test_interleave();
      test_stall();
      test_flush_same();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
